// File: rtl/pixel_stream_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_stream_sequencer                                                     |
// | Streams an N x N frame from RAM onto the kernel bus, then sweeps results.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pixel_stream_sequencer #(
  parameter int N          = 8,
  parameter int bitSize    = 6,
  parameter int pixelWidth = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [bitSize:0]      frame_rd_addr,
  input  logic [pixelWidth-1:0] frame_rd_data,
  output logic                  we,
  output logic [bitSize:0]      pixel_position_or_address,
  output logic [pixelWidth-1:0] data_out,
  output logic                  result_strobe,
  output logic                  busy,
  output logic                  done
);

  localparam int              c_aw       = bitSize + 1;
  localparam logic [c_aw-1:0] c_last     = c_aw'(N * N - 1);
  localparam logic [c_aw-1:0] c_one      = c_aw'(1);
  localparam logic [c_aw-1:0] c_first_rd = (N * N > 1) ? c_one : '0;

  generate
    if (N * N > (1 << c_aw)) begin : g_size_check
      $error("pixel_stream_sequencer: N*N does not fit in the address bus");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_WRITE = 3'd2,
    S_GAP   = 3'd3,
    S_READ  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                r_state;
  logic                  r_sub;
  logic [c_aw-1:0]       r_slot;
  logic [c_aw-1:0]       r_rd_addr;
  logic                  r_we;
  logic [c_aw-1:0]       r_addr;
  logic [pixelWidth-1:0] r_data;
  logic                  r_strobe;
  logic                  r_busy;
  logic                  r_done;

  logic [c_aw-1:0]       w_slot_nxt;
  logic [c_aw-1:0]       w_rd_nxt;

  // Prefetch address for the slot after next; the final slot parks on the last pixel.
  assign w_slot_nxt = r_slot + c_one;
  assign w_rd_nxt   = (w_slot_nxt == c_last) ? c_last : (w_slot_nxt + c_one);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sub     <= 1'b0;
      r_slot    <= '0;
      r_rd_addr <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_strobe  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      if (abort && (r_state != S_DONE)) begin
        r_state   <= S_IDLE;
        r_sub     <= 1'b0;
        r_slot    <= '0;
        r_rd_addr <= '0;
        r_we      <= 1'b0;
        r_addr    <= '0;
        r_data    <= '0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state   <= S_PRIME;
              r_busy    <= 1'b1;
              r_rd_addr <= '0;
            end
          end
          S_PRIME: begin
            // Address 0 has been on the RAM since IDLE, so pixel 0 is already valid.
            r_state   <= S_WRITE;
            r_sub     <= 1'b0;
            r_slot    <= '0;
            r_we      <= 1'b1;
            r_addr    <= '0;
            r_data    <= frame_rd_data;
            r_rd_addr <= c_first_rd;
          end
          S_WRITE: begin
            if (!r_sub) begin
              r_sub <= 1'b1;
            end else if (r_slot == c_last) begin
              r_state   <= S_GAP;
              r_sub     <= 1'b0;
              r_we      <= 1'b0;
              r_addr    <= '0;
              r_data    <= '0;
              r_rd_addr <= '0;
            end else begin
              r_sub     <= 1'b0;
              r_slot    <= w_slot_nxt;
              r_addr    <= w_slot_nxt;
              r_data    <= frame_rd_data;
              r_rd_addr <= w_rd_nxt;
            end
          end
          S_GAP: begin
            if (!r_sub) begin
              r_sub <= 1'b1;
            end else begin
              r_state <= S_READ;
              r_sub   <= 1'b0;
              r_slot  <= '0;
              r_addr  <= '0;
            end
          end
          S_READ: begin
            if (!r_sub) begin
              r_sub    <= 1'b1;
              r_strobe <= 1'b1;
            end else if (r_slot == c_last) begin
              r_state <= S_DONE;
              r_sub   <= 1'b0;
              r_addr  <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_sub  <= 1'b0;
              r_slot <= w_slot_nxt;
              r_addr <= w_slot_nxt;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_sub   <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign frame_rd_addr             = r_rd_addr;
  assign we                        = r_we;
  assign pixel_position_or_address = r_addr;
  assign data_out                  = r_data;
  assign result_strobe             = r_strobe;
  assign busy                      = r_busy;
  assign done                      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pixel_stream_sequencer                                                  |
// | Directed bench: full passes, busy-start, abort, back-to-back, async reset. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pixel_stream_sequencer;

  localparam int N      = 8;
  localparam int BS     = 6;
  localparam int PW     = 8;
  localparam int P      = N * N;
  localparam int PERIOD = 4 * P + 5;  // PRIME..DONE plus one IDLE cycle

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [BS:0]   frame_rd_addr;
  logic [PW-1:0] frame_rd_data;
  logic          we;
  logic [BS:0]   pixel_position_or_address;
  logic [PW-1:0] data_out;
  logic          result_strobe;
  logic          busy;
  logic          done;

  logic [PW-1:0] ram [0:(1 << (BS + 1)) - 1];
  int            n_pass  = 0;
  int            n_total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) frame_rd_data <= ram[frame_rd_addr];

  pixel_stream_sequencer #(
    .N         (N),
    .bitSize   (BS),
    .pixelWidth(PW)
  ) u_dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .start                    (start),
    .abort                    (abort),
    .frame_rd_addr            (frame_rd_addr),
    .frame_rd_data            (frame_rd_data),
    .we                       (we),
    .pixel_position_or_address(pixel_position_or_address),
    .data_out                 (data_out),
    .result_strobe            (result_strobe),
    .busy                     (busy),
    .done                     (done)
  );

  task automatic check(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle %0d: observed %h expected %h", tag, c, obs, exp);
  endtask

  // {busy, done, we, result_strobe, address, data} expected in pass-local cycle c
  function automatic logic [18:0] exp_bus(input int c);
    logic         b, d, w, s;
    logic [BS:0]  a;
    logic [PW-1:0] p;
    int           k;
    b = 1'b0; d = 1'b0; w = 1'b0; s = 1'b0; a = '0; p = '0; k = 0;
    if (c < 1) begin
      b = 1'b0;
    end else if (c == 1) begin
      b = 1'b1;
    end else if (c <= 2 * P + 1) begin
      k = (c - 2) / 2;
      b = 1'b1; w = 1'b1; a = (BS + 1)'(k); p = ram[k];
    end else if (c <= 2 * P + 3) begin
      b = 1'b1;
    end else if (c <= 4 * P + 3) begin
      k = (c - 2 * P - 4) / 2;
      b = 1'b1; a = (BS + 1)'(k); s = ((c - 2 * P - 4) % 2) == 1;
    end else if (c == 4 * P + 4) begin
      d = 1'b1;
    end
    return {b, d, w, s, a, p};
  endfunction

  function automatic logic [18:0] obs_bus();
    return {busy, done, we, result_strobe, pixel_position_or_address, data_out};
  endfunction

  // Caller raises start for cycle 0; the task walks cycles 1..ncyc checking every cycle.
  task automatic run(input string tag, input int ncyc, input int s_lo, input int s_hi,
                     input int abort_at, input bit wrap);
    int lc;
    int k;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start = (c >= s_lo) && (c <= s_hi);
      abort = (c == abort_at);
      @(negedge clk);
      lc = wrap ? ((c - 1) % PERIOD) + 1 : c;
      if (abort_at > 0 && c > abort_at) begin
        check({tag, "_bus"}, c, 32'(obs_bus()), 32'(19'd0));
      end else begin
        check({tag, "_bus"}, c, 32'(obs_bus()), 32'(exp_bus(lc)));
        if (lc == 1) begin
          check({tag, "_rdaddr"}, c, 32'(frame_rd_addr), 32'd0);
        end else if (lc >= 2 && lc <= 2 * P + 1 && ((lc - 2) % 2) == 0) begin
          k = (lc - 2) / 2;
          check({tag, "_rdaddr"}, c, 32'(frame_rd_addr), (k == P - 1) ? 32'(P - 1) : 32'(k + 1));
        end
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic idle_cycles(input string tag, input int ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      check({tag, "_bus"}, c, 32'(obs_bus()), 32'd0);
      check({tag, "_rdaddr"}, c, 32'(frame_rd_addr), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << (BS + 1)); i++) ram[i] = PW'(i + 16);

    repeat (3) @(posedge clk);
    #1;
    check("reset_bus", 0, 32'(obs_bus()), 32'd0);
    check("reset_rdaddr", 0, 32'(frame_rd_addr), 32'd0);
    rst_n = 1'b1;
    idle_cycles("idle", 20);

    start = 1'b1;
    run("pass", PERIOD + 1, 0, 0, 0, 1'b0);

    start = 1'b1;
    run("busy_start", PERIOD + 1, 50, 100, 0, 1'b0);

    start = 1'b1;
    run("abort", 80, 0, 0, 70, 1'b0);

    // New pixel pattern, then abort and start together in IDLE must not launch a pass.
    for (int i = 0; i < (1 << (BS + 1)); i++) ram[i] = PW'(i * 37 + 5);
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("abort_wins_bus", 0, 32'(obs_bus()), 32'd0);

    start = 1'b1;
    run("after_abort", PERIOD + 1, 0, 0, 0, 1'b0);

    start = 1'b1;
    run("b2b", 2 * PERIOD, 0, 1 << 30, 0, 1'b1);
    idle_cycles("b2b_tail", 3);

    start = 1'b1;
    run("pre_rst", 199, 0, 0, 0, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_bus", 200, 32'(obs_bus()), 32'd0);
    check("async_rst_rdaddr", 200, 32'(frame_rd_addr), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_held_bus", 203, 32'(obs_bus()), 32'd0);
    rst_n = 1'b1;
    idle_cycles("post_rst", 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
